// File: rtl/l2_task_fire_arbiter.sv
// Round-robin arbiter sharing the L2 task-fire port among NUM_REQ DAG schedulers.
// Optional hung-fire watchdog enabled by defining L2_FIRE_WATCHDOG_EN.

package l2_task_fire_arbiter_pkg;

  localparam int MAX_DAG_NUM = 4;

  typedef struct packed {
    logic        pseudo_fire_flag;
    logic [7:0]  dag_id;
    logic [15:0] task_id;
  } task_manager_req_t;

  typedef struct packed {
    logic task_fire_req_ack;
    logic skip_code_transmittion_flag;
    logic task_fire_req_nack;
  } task_manager_resp_t;

endpackage

module l2_task_fire_arbiter
  import l2_task_fire_arbiter_pkg::*;
#(
  parameter int  NUM_REQ        = MAX_DAG_NUM,
  parameter int  TIMEOUT_CYCLES = 1024,
  localparam int IDW            = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  task_manager_req_t  req_i [NUM_REQ],
  output task_manager_resp_t resp_o [NUM_REQ],
  output logic               fire_valid_o,
  output task_manager_req_t  fire_req_o,
  input  task_manager_resp_t fire_resp_i,
  output logic               busy_o,
  output logic [IDW-1:0]     grant_id_o,
  output logic               timeout_o
);

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("l2_task_fire_arbiter: NUM_REQ must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("l2_task_fire_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     last_ptr_q;
  logic [IDW-1:0]     grant_q;
  task_manager_req_t  fire_req_q;
  task_manager_resp_t resp_q;

  logic               any_valid;
  logic [IDW-1:0]     winner;
  logic [IDW-1:0]     cand;
  logic               load_grant;
  logic               capture_resp;
  logic               resp_seen;

  assign resp_seen = fire_resp_i.task_fire_req_ack | fire_resp_i.task_fire_req_nack;

  // Rotating priority: scan starts one past the last served requester.
  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    cand      = last_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (cand == IDW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!any_valid && req_valid_i[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

`ifdef L2_FIRE_WATCHDOG_EN
  logic [31:0] wd_cnt_q;
  logic        wd_expire;
  logic        timeout_q;
`endif

  always_comb begin
    state_d      = state_q;
    load_grant   = 1'b0;
    capture_resp = 1'b0;
`ifdef L2_FIRE_WATCHDOG_EN
    wd_expire    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          load_grant = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        // A real response on the expiry cycle takes precedence over the watchdog.
        if (resp_seen) begin
          capture_resp = 1'b1;
          state_d      = RESP;
        end
`ifdef L2_FIRE_WATCHDOG_EN
        else if (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          wd_expire = 1'b1;
          state_d   = RESP;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the payload register is reset too, so fire_req_o is defined from the first cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_ptr_q <= IDW'(NUM_REQ - 1);
      grant_q    <= '0;
      fire_req_q <= '0;
      resp_q     <= '0;
    end else begin
      if (load_grant) begin
        grant_q    <= winner;
        fire_req_q <= req_i[winner];
      end
      if (capture_resp) begin
        resp_q <= '{task_fire_req_ack:           fire_resp_i.task_fire_req_ack,
                    skip_code_transmittion_flag: fire_resp_i.skip_code_transmittion_flag,
                    task_fire_req_nack:          fire_resp_i.task_fire_req_nack &
                                                 ~fire_resp_i.task_fire_req_ack};
      end
`ifdef L2_FIRE_WATCHDOG_EN
      if (wd_expire) begin
        resp_q <= '{task_fire_req_ack: 1'b0, skip_code_transmittion_flag: 1'b0,
                    task_fire_req_nack: 1'b1};
      end
`endif
      if (state_q == RESP) begin
        last_ptr_q <= grant_q;
      end
    end
  end

`ifdef L2_FIRE_WATCHDOG_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (load_grant) begin
        wd_cnt_q <= '0;
      end else if (state_q == BUSY) begin
        wd_cnt_q <= wd_cnt_q + 32'd1;
      end
      // Lines up with the RESP cycle that carries the synthesized nack.
      timeout_q <= wd_expire;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign fire_valid_o = (state_q == BUSY);
  assign fire_req_o   = (state_q == BUSY) ? fire_req_q : '0;
  assign busy_o       = (state_q != IDLE);
  assign grant_id_o   = grant_q;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_o[i] = '0;
      if ((state_q == RESP) && (grant_q == IDW'(i))) begin
        resp_o[i] = resp_q;
      end
    end
  end

endmodule

// File: doc/l2_task_fire_arbiter.md
# l2_task_fire_arbiter

Round-robin arbiter that shares the single downstream task-fire port (`task_manager_req_t` / `task_manager_resp_t`) among `NUM_REQ` DAG scheduler instances in the L2 scheduler. It holds one request at a time, keeps the grant until the task manager answers with ack or nack, and returns that answer as a one-cycle pulse to the winning requester. An optional watchdog converts a hung fire into a synthesized nack.

## Interface
- `NUM_REQ`, default `MAX_DAG_NUM` (4): number of requesters; must be ≥2.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit in cycles spent in BUSY; used only with `L2_FIRE_WATCHDOG_EN`.
- `IDW`, derived as `$clog2(NUM_REQ)`: width of the grant ID.

- `clk_i` in 1: single clock; all state is on the rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in `[NUM_REQ]`: per-requester request valid; held until the matching `resp_o` pulse.
- `req_i` in `[NUM_REQ]` × `task_manager_req_t`: per-requester request payload; stable while valid.
- `resp_o` out `[NUM_REQ]` × `task_manager_resp_t`: per-requester response; nonzero only during the one-cycle response pulse.
- `fire_valid_o` out 1: downstream request valid.
- `fire_req_o` out `task_manager_req_t`: latched payload of the granted request.
- `fire_resp_i` in `task_manager_resp_t`: downstream response; `task_fire_req_ack` / `task_fire_req_nack` are single-cycle pulses.
- `busy_o` out 1: high when state ≠ IDLE.
- `grant_id_o` out IDW: index of the current or last grant.
- `timeout_o` out 1: one-cycle pulse when the watchdog fires.

## Operation
- Uses a 3-state FSM: IDLE, BUSY, RESP.
- **IDLE**
  - If any `req_valid_i` is set, pick the first set bit scanning from `last_ptr+1` modulo `NUM_REQ`.
  - Latch the winner's `req_i` into `fire_req_q` and its index into `grant_q`, clear the watchdog counter, then go to BUSY.
  - With no valid request, stay in IDLE.
- **BUSY**
  - `fire_valid_o`=1 and `fire_req_o`=`fire_req_q`. The latched payload is used even if the requester changes `req_i`.
  - When ack or nack arrives, capture `fire_resp_i` into `resp_q` and go to RESP.
  - If ack and nack arrive in the same cycle, ack wins: capture `ack=1`, `nack=0`, and the skip flag as received.
  - `skip_code_transmittion_flag` is forwarded unchanged.
- **RESP**
  - `resp_o[grant_q]`=`resp_q` for exactly one cycle; every other `resp_o` entry is 0.
  - Set `last_ptr`←`grant_q`, then go to IDLE.
- Requesters deassert valid in the cycle after the pulse unless they are presenting a new request. A re-asserted request is arbitrated normally, so it is not starved and not favored.
- `pseudo_fire_flag` gets no special treatment; it passes through in `fire_req_o`.
- `req_valid_i` changes while BUSY or RESP are ignored; only IDLE samples them.
- A requester that drops valid before its response still receives the pulse, and the pulse is harmless.
- `fire_resp_i` pulses arriving in IDLE or RESP are ignored.

## Timing
- Reset values:
  - state=IDLE, `last_ptr`=`NUM_REQ-1` (so requester 0 wins first), `grant_q`=0, `fire_req_q`=0, `resp_q`=0, watchdog counter=0.
  - Outputs: `fire_valid_o`=0, `fire_req_o`=0, `resp_o`=all 0, `busy_o`=0, `grant_id_o`=0, `timeout_o`=0.
- Reset asserted mid-operation aborts the fire immediately. No response is returned, and downstream sees `fire_valid_o` drop asynchronously.
- Latency:
  - Valid sampled in IDLE at cycle t → `fire_valid_o`=1 at t+1.
  - Ack/nack at cycle k → `resp_o` pulse at k+1 → IDLE at k+2.
  - The earliest next `fire_valid_o` is at k+3.
- `fire_valid_o` never drops without a response or a timeout, and is never high in IDLE or RESP.
- All outputs are registered or decoded from registered state. There is no combinational path from `req_*` to `fire_*` or from `fire_resp_i` to `resp_o`.

## Configuration
- **`L2_FIRE_WATCHDOG_EN` defined**
  - A 32-bit counter increments every cycle in BUSY.
  - If the counter reaches `TIMEOUT_CYCLES-1` with no response, the block goes to RESP with `resp_q`={ack=0, skip=0, nack=1} and pulses `timeout_o` in that cycle.
  - A response arriving on the same cycle as expiry wins over the timeout.
- **Not defined:** the counter is not instantiated, `timeout_o` is tied 0, and BUSY waits indefinitely.

## Test plan
- **Single request:** req 2 valid at t=0; ack at t=4 → `fire_valid_o` high t=1..4, `fire_req_o`=req_i[2], `resp_o[2].ack`=1 at t=5 only, `grant_id_o`=2.
- **Round-robin fairness:** all 4 requesters hold valid and downstream acks 3 cycles after each `fire_valid_o` → grant order 0,1,2,3,0; no `resp_o` overlap.
- **Simultaneous ack+nack:** both pulsed with skip=1 → `resp_o` = {ack=1, skip=1, nack=0}.
- **Nack pass-through:** nack on req 1 → `resp_o[1].nack`=1; requester re-asserts and is served only after the pending req 2 and 3.
- **Reset mid-BUSY:** drop `rst_ni` at t=2 of a fire → all outputs 0 immediately; after release, requester 0 wins first.
- **Watchdog (`L2_FIRE_WATCHDOG_EN`, `TIMEOUT_CYCLES`=16):** no response → `timeout_o` and `resp_o[g].nack`=1 at t=17. Without the macro, still BUSY at t=1000.
